// File: rtl/tx_frame_buffer.sv
// tx_frame_buffer: store-and-forward AXIS frame FIFO feeding the 32-bit TX MAC.
// Latency: input tlast at edge N -> m00_axis_tvalid high after edge N+2 (idle buffer); one bubble between frames.
// Backpressure: none upstream (tready stays 1, frames that do not fit are dropped whole); m00 holds on tready=0.
//
// Ports:
//   clk, reset            single clock, asynchronous active-low reset (release synchronised internally)
//   s00_axis_*            user frame input; tkeep only meaningful on tlast
//   m00_axis_*            frame output to the MAC; tvalid is continuous from first to last beat
//   frame_count           complete frames stored and not yet fully read
//   drop_count            frames dropped, saturating at 16'hFFFF
//   drop_pulse            one-cycle pulse when a dropped frame's tlast is accepted
module tx_frame_buffer #(
  parameter  int DEPTH       = 512,
  localparam int DATA_WIDTH  = 32,
  localparam int DATA_NBYTES = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic [DATA_WIDTH-1:0]    s00_axis_tdata,
  input  logic [DATA_NBYTES-1:0]   s00_axis_tkeep,
  input  logic                     s00_axis_tvalid,
  output logic                     s00_axis_tready,
  input  logic                     s00_axis_tlast,

  output logic [DATA_WIDTH-1:0]    m00_axis_tdata,
  output logic [DATA_NBYTES-1:0]   m00_axis_tkeep,
  output logic                     m00_axis_tvalid,
  input  logic                     m00_axis_tready,
  output logic                     m00_axis_tlast,

  output logic [$clog2(DEPTH):0]   frame_count,
  output logic [15:0]              drop_count,
  output logic                     drop_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 1 + DATA_NBYTES + DATA_WIDTH;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PRIME,
    RD_STREAM
  } rd_state_t;

  // Reset release synchroniser. Assertion is asynchronous through the flop
  // reset; the input side only opens once release has passed two flops.
  logic [1:0] rst_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign s00_axis_tready = rst_sync[1];

  // Pointers carry one extra wrap bit so that full (DEPTH) and empty (0)
  // occupancy are distinguishable.
  logic [PW-1:0] wr_spec;    // next write slot for the frame being received
  logic [PW-1:0] wr_commit;  // end of the last complete frame; reader never passes it
  logic [PW-1:0] rd_ptr;     // next word to move into the output register
  logic          drop_flag;  // discarding the remainder of an oversized frame
  logic [PW-1:0] occupancy;
  logic          full;

  logic          wr_accept;
  logic          wr_store;
  logic          wr_commit_evt;
  logic          rd_done_evt;
  logic [PW-1:0] frame_count_nxt;

  rd_state_t     rd_state;

  logic [EW-1:0] mem [DEPTH];

  assign occupancy     = wr_spec - rd_ptr;
  assign full          = (occupancy == PW'(DEPTH));
  assign wr_accept     = s00_axis_tvalid && s00_axis_tready;
  assign wr_store      = wr_accept && !drop_flag && !full;
  assign wr_commit_evt = wr_store && s00_axis_tlast;

  // In STREAM the output register always holds a valid beat, so a handshake
  // there is simply STREAM && tready.
  assign rd_done_evt   = (rd_state == RD_STREAM) && m00_axis_tready && m00_axis_tlast;

  // A commit and a completed read in the same cycle cancel out.
  assign frame_count_nxt = frame_count + PW'(wr_commit_evt) - PW'(rd_done_evt);

  // Frame storage: plain synchronous RAM, no reset.
  always_ff @(posedge clk) begin
    if (wr_store) begin
      mem[wr_spec[AW-1:0]] <= {s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata};
    end
  end

  // Write side: speculative pointer for the frame in flight, committed
  // pointer advanced only on a stored tlast. A frame that hits full rewinds
  // wr_spec to wr_commit so the committed frames are untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_spec    <= '0;
      wr_commit  <= '0;
      drop_flag  <= 1'b0;
      drop_count <= 16'h0000;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (wr_accept) begin
        if (drop_flag) begin
          if (s00_axis_tlast) begin
            drop_flag  <= 1'b0;
            drop_pulse <= 1'b1;
            if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
          end
        end else if (full) begin
          wr_spec <= wr_commit;
          if (s00_axis_tlast) begin
            // The overflowing beat is also the last one: finish the drop
            // now rather than leave the flag armed for the next frame.
            drop_pulse <= 1'b1;
            if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
          end else begin
            drop_flag <= 1'b1;
          end
        end else begin
          wr_spec <= wr_spec + PW'(1);
          if (s00_axis_tlast) begin
            wr_commit <= wr_spec + PW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
    end else begin
      frame_count <= frame_count_nxt;
    end
  end

  // Read side. Only whole frames are counted in frame_count, so once a
  // frame is started every following word up to its tlast is already in
  // memory and tvalid can stay high for the whole frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state        <= RD_IDLE;
      rd_ptr          <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tkeep  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          m00_axis_tvalid <= 1'b0;
          if (frame_count != '0) begin
            rd_state <= RD_PRIME;
          end
        end

        RD_PRIME: begin
          {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata} <= mem[rd_ptr[AW-1:0]];
          rd_ptr          <= rd_ptr + PW'(1);
          m00_axis_tvalid <= 1'b1;
          rd_state        <= RD_STREAM;
        end

        RD_STREAM: begin
          if (m00_axis_tready) begin
            if (m00_axis_tlast) begin
              m00_axis_tvalid <= 1'b0;
              rd_state        <= (frame_count_nxt != '0) ? RD_PRIME : RD_IDLE;
            end else begin
              {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata} <= mem[rd_ptr[AW-1:0]];
              rd_ptr <= rd_ptr + PW'(1);
            end
          end
        end

        default: begin
          rd_state        <= RD_IDLE;
          m00_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule
